// File: rtl/dma_pcie_rq_pkg.sv
// Shared definitions for the PCIe RQ receiver: descriptor layout, request
// types, FSM states and small decode helpers.
package dma_pcie_rq_pkg;

  localparam int DESC_DWS  = 4;
  localparam int ADDR_LSB  = 2;
  localparam int ADDR_MSB  = 63;
  localparam int DWCNT_LSB = 64;
  localparam int DWCNT_MSB = 74;
  localparam int TYPE_LSB  = 75;
  localparam int TYPE_MSB  = 78;
  localparam int TAG_LSB   = 96;
  localparam int TAG_MSB   = 103;

  typedef enum logic [3:0] {
    MEM_RD = 4'b0000,
    MEM_WR = 4'b0001
  } rq_type_e;

  typedef enum logic {
    ST_SOP,
    ST_PAYLOAD
  } rq_state_e;

  typedef struct packed {
    logic [63:0] addr;
    logic [10:0] dwcnt;
    logic [3:0]  rtype;
    logic [7:0]  tag;
  } rq_desc_t;

  typedef struct packed {
    rq_desc_t desc;
    logic     err;
  } rq_hdr_t;

  // Reads carry no payload; only writes expect dwcnt DWs of data.
  function automatic logic [10:0] expected_dws(input logic [3:0] rtype, input logic [10:0] dwcnt);
    return (rtype == MEM_WR) ? dwcnt : 11'd0;
  endfunction

  function automatic logic type_known(input logic [3:0] rtype);
    return (rtype == MEM_RD) || (rtype == MEM_WR);
  endfunction

endpackage

// File: rtl/dma_pcie_axis_rq_if.sv
// AXI-Stream requester-request bundle; the receiver uses the slave modport.
interface dma_pcie_axis_rq_if #(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 137
);
  logic [DATA_WIDTH-1:0]    tdata;
  logic                     tlast;
  logic [USER_WIDTH-1:0]    tuser;
  logic [DATA_WIDTH/32-1:0] tkeep;
  logic                     tvalid;
  logic                     tready;

  modport s (input tdata, tlast, tuser, tkeep, tvalid, output tready);
  modport m (output tdata, tlast, tuser, tkeep, tvalid, input tready);
endinterface

// File: rtl/dma_pcie_rq_hdr_fifo.sv
// Synchronous first-word-fall-through FIFO for decoded request headers.
// A push while full is accepted only when a pop happens in the same cycle.
module dma_pcie_rq_hdr_fifo #(
  parameter int  WIDTH = 88,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dma_pcie_rq_rcv.sv
// PCIe RQ receiver: decodes the SOP descriptor, checks payload length and
// tkeep shape, and queues one header entry per packet for the consumer.
module dma_pcie_rq_rcv
  import dma_pcie_rq_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 137,
  parameter int HDR_DEPTH  = 4
) (
  input  logic                user_clk,
  input  logic                user_reset,
  dma_pcie_axis_rq_if.s       rq,
  output logic                hdr_vld,
  input  logic                hdr_rdy,
  output logic [63:0]         hdr_addr,
  output logic [10:0]         hdr_dwcnt,
  output logic [3:0]          hdr_type,
  output logic [7:0]          hdr_tag,
  output logic                hdr_err,
  output logic [31:0]         pkt_cnt,
  output logic [15:0]         err_cnt
);

  localparam int NK = DATA_WIDTH / 32;
  localparam int CW = $clog2(HDR_DEPTH) + 1;

  rq_state_e       state_q, state_nxt;
  rq_desc_t        desc_in, desc_cur, desc_p1;
  logic [10:0]     exp_cur, exp_p1, cnt_p1;
  logic            ovf_p1, err_p1, tready_p1;
  logic            acc, sop, push, pop;
  logic            beat_err, ovf_cur, err_cur, pkt_err;
  logic [NK-1:0]   beat_keep;
  logic [11:0]     sum;
  rq_hdr_t         fifo_din, fifo_dout;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count, count_nxt;
  logic [USER_WIDTH-1:0] unused_user;
  logic            unused_bits;

  function automatic logic [11:0] beat_dws(input logic [NK-1:0] k);
    logic [11:0] c;
    c = '0;
    for (int i = 0; i < NK; i++) c = c + 12'(k[i]);
    return c;
  endfunction

  // A valid keep is a run of ones from bit 0, i.e. of the form 2^n-1.
  function automatic logic keep_gap(input logic [NK-1:0] k);
    return (k & (k + NK'(1))) != '0;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign unused_user = rq.tuser;
  assign unused_bits = ^{unused_user, rq.tdata[DATA_WIDTH-1:TAG_MSB+1],
                         rq.tdata[TAG_LSB-1:TYPE_MSB+1], rq.tdata[ADDR_LSB-1:0]};

  assign desc_in = {rq.tdata[ADDR_MSB:ADDR_LSB], 2'b00, rq.tdata[DWCNT_MSB:DWCNT_LSB],
                    rq.tdata[TYPE_MSB:TYPE_LSB], rq.tdata[TAG_MSB:TAG_LSB]};

  assign acc       = rq.tvalid && tready_p1;
  assign sop       = (state_q == ST_SOP);
  assign push      = acc && rq.tlast;
  assign pop       = hdr_vld && hdr_rdy;
  assign desc_cur  = sop ? desc_in : desc_p1;
  assign exp_cur   = sop ? expected_dws(desc_in.rtype, desc_in.dwcnt) : exp_p1;
  // On SOP the low DWs hold the descriptor and never count as payload.
  assign beat_keep = sop ? {rq.tkeep[NK-1:DESC_DWS], {DESC_DWS{1'b0}}} : rq.tkeep;
  assign sum       = {1'b0, (sop ? 11'd0 : cnt_p1)} + beat_dws(beat_keep);
  assign ovf_cur   = (!sop && ovf_p1) || sum[11];
  assign beat_err  = keep_gap(rq.tkeep) ||
                     (sop && ((rq.tkeep[DESC_DWS-1:0] != {DESC_DWS{1'b1}}) ||
                              !type_known(desc_in.rtype) ||
                              (desc_in.rtype == MEM_WR && desc_in.dwcnt == 11'd0)));
  assign err_cur   = (!sop && err_p1) || beat_err;
  assign pkt_err   = err_cur || ovf_cur || (sum[10:0] != exp_cur);
  assign count_nxt = fifo_count + CW'(push) - CW'(pop);
  assign fifo_din  = '{desc: desc_cur, err: pkt_err};

  always_comb begin
    state_nxt = state_q;
    if (acc) state_nxt = rq.tlast ? ST_SOP : ST_PAYLOAD;
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) state_q <= ST_SOP;
    else            state_q <= state_nxt;
  end

  // ---- stage p1: per-packet running state, counters, registered tready ----
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      cnt_p1    <= '0;
      ovf_p1    <= 1'b0;
      err_p1    <= 1'b0;
      tready_p1 <= 1'b0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      tready_p1 <= (count_nxt != CW'(HDR_DEPTH));
      if (acc) begin
        if (rq.tlast) begin
          cnt_p1 <= '0;
          ovf_p1 <= 1'b0;
          err_p1 <= 1'b0;
        end else begin
          cnt_p1 <= sum[10:0];
          ovf_p1 <= ovf_cur;
          err_p1 <= err_cur;
        end
      end
      if (push) begin
        pkt_cnt <= pkt_cnt + 32'd1;
        if (pkt_err) err_cnt <= sat_inc16(err_cnt);
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (acc && sop) begin
      desc_p1 <= desc_in;
      exp_p1  <= exp_cur;
    end
  end

  dma_pcie_rq_hdr_fifo #(
    .WIDTH ($bits(rq_hdr_t)),
    .DEPTH (HDR_DEPTH)
  ) u_hdr_fifo (
    .clk   (user_clk),
    .rst   (user_reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rq.tready = tready_p1 && !(fifo_full && 1'b0);
  assign hdr_vld   = !fifo_empty;
  assign hdr_addr  = fifo_dout.desc.addr;
  assign hdr_dwcnt = fifo_dout.desc.dwcnt;
  assign hdr_type  = fifo_dout.desc.rtype;
  assign hdr_tag   = fifo_dout.desc.tag;
  assign hdr_err   = fifo_dout.err;

endmodule

// File: doc/dma_pcie_rq_rcv.md
DMA_PCIE_RQ_RCV -- requirements
Module: dma_pcie_rq_rcv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning the RQ tdata width in bits.
REQ-002 SHALL have parameter USER_WIDTH, default 137, meaning the RQ tuser width in bits.
REQ-003 SHALL have parameter HDR_DEPTH, default 4, meaning header FIFO entries (power of 2).
REQ-004 SHALL have port user_clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port user_reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rq, dma_pcie_axis_rq_if slave modport (s): tdata, tlast, tuser, tkeep[DATA_WIDTH/32-1:0], tvalid in; tready out.
REQ-007 SHALL have port hdr_vld, output, 1, meaning a decoded request is available.
REQ-008 SHALL have port hdr_rdy, input, 1, meaning the consumer accepts the head entry.
REQ-009 SHALL have ports hdr_addr (output, 64), hdr_dwcnt (output, 11), hdr_type (output, 4), hdr_tag (output, 8) and hdr_err (output, 1), meaning the fields of the head entry.
REQ-010 SHALL have port pkt_cnt, output, 32, meaning accepted packets (wrapping).
REQ-011 SHALL have port err_cnt, output, 16, meaning errored packets (saturating at 16'hFFFF).

Function
REQ-012 SHALL decode the first beat of each packet (SOP) as the descriptor: addr = tdata[63:2] with 2'b00 appended; dwcnt = tdata[74:64]; type = tdata[78:75]; tag = tdata[103:96].
REQ-013 SHALL count only DWs beyond descriptor DW0-3 as payload on the SOP beat, and all tkeep-set DWs on later beats.
REQ-014 SHALL set expected payload to dwcnt for MemWr (type 4'b0001) and to 0 for MemRd (type 4'b0000); dwcnt 11'd0 on MemWr is an error.
REQ-015 SHALL run FSM states SOP and PAYLOAD: SOP->PAYLOAD on an accepted beat with tlast=0; PAYLOAD->SOP on an accepted beat with tlast=1; SOP stays in SOP on an accepted beat with tlast=1.
REQ-016 SHALL set err for a packet if any of: payload count != expected; tkeep non-contiguous (a 1 above a 0); unknown type; SOP beat with tkeep[3:0] != 4'hF.
REQ-017 SHALL push {addr, dwcnt, type, tag, err} into the header FIFO on the accepted tlast beat, with hdr_vld asserting the cycle after the push.
REQ-018 SHALL drive tready = !fifo_full, registered, so that tready is low in the cycle after the FIFO reaches HDR_DEPTH entries, including mid-packet.
REQ-019 SHALL allow a simultaneous push and pop when full; in that case tready stays high.
REQ-020 SHALL pop the FIFO on hdr_vld && hdr_rdy and hold the head fields stable while hdr_vld=1 and hdr_rdy=0.
REQ-021 SHALL use an 11-bit payload counter with a sticky overflow bit, so that more than 2047 DWs yields err.
REQ-022 SHALL increment pkt_cnt on each push, and err_cnt on each push with err=1 unless err_cnt is already saturated.
REQ-023 SHALL treat a beat as accepted only when tvalid && tready, and ignore tdata, tkeep and tlast otherwise.

Reset
REQ-024 SHALL, while user_reset=1 on a user_clk edge, reset FSM=SOP, FIFO empty, hdr_vld=0, tready=0, pkt_cnt=0, err_cnt=0 and the payload counter plus err flags to 0.
REQ-025 SHALL drive tready=1 on the first cycle after reset deasserts.
REQ-026 SHALL discard a packet in flight when reset asserts mid-packet, with no FIFO entry produced, and treat the next accepted beat as SOP.

Structure
REQ-027 SHALL place the RQ descriptor struct, the request-type enum (MEM_RD, MEM_WR) and the bit-offset constants in a shared package dma_pcie_rq_pkg.
REQ-028 SHALL implement the header FIFO as sub-module dma_pcie_rq_hdr_fifo (sync, first-word-fall-through, full/empty/count).

Verification
REQ-029 SHALL verify: MemRd, dwcnt=16, tag=0x5A, single beat with tkeep=16'h000F and tlast -> one entry with type=0, tag=0x5A, err=0, pkt_cnt=1.
REQ-030 SHALL verify: MemWr, dwcnt=28, beat0 tkeep=16'hFFFF then beat1 tkeep=16'hFFFF with tlast -> err=0 (12+16=28).
REQ-031 SHALL verify: MemWr, dwcnt=20, payload 12+4 DWs -> err=1 and err_cnt=1.
REQ-032 SHALL verify: beat tkeep=16'h0F0F -> err=1.
REQ-033 SHALL verify: hdr_rdy=0 with 5 single-beat MemRd packets -> 4 entries, tready low after the 4th, 5th beat held; one pop -> 5th accepted.
REQ-034 SHALL verify: user_reset pulsed after beat0 of a 3-beat MemWr -> no entry, pkt_cnt=0, next packet decodes correctly.
